// File: rtl/or10_wb_arbiter_2x1.sv
// or10_wb_arbiter_2x1
// Two-master, one-slave Wishbone arbiter with round-robin grant and bus lock.
// A master keeps the slave for as long as it holds cyc. When both masters
// request from idle, the one that did not own the bus last wins. A handover
// to a waiting master happens without an idle cycle in between.
// Optional feature: define OR10_WB_ARB_TIMEOUT_EN to build in a slave
// no-response watchdog. It answers a stalled strobe with a one-cycle err
// after TIMEOUT_CYCLES stalled cycles.
module or10_wb_arbiter_2x1 #(
  parameter int TIMEOUT_CYCLES   = 255,
  parameter int RESET_LAST_GRANT = 1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  // master 0
  input  logic        m0_wb_cyc_i,
  input  logic        m0_wb_stb_i,
  input  logic [31:0] m0_wb_adr_i,
  input  logic [3:0]  m0_wb_sel_i,
  input  logic        m0_wb_we_i,
  input  logic [31:0] m0_wb_dat_i,
  output logic [31:0] m0_wb_dat_o,
  output logic        m0_wb_ack_o,
  output logic        m0_wb_err_o,
  // master 1
  input  logic        m1_wb_cyc_i,
  input  logic        m1_wb_stb_i,
  input  logic [31:0] m1_wb_adr_i,
  input  logic [3:0]  m1_wb_sel_i,
  input  logic        m1_wb_we_i,
  input  logic [31:0] m1_wb_dat_i,
  output logic [31:0] m1_wb_dat_o,
  output logic        m1_wb_ack_o,
  output logic        m1_wb_err_o,
  // shared slave
  output logic        s_wb_cyc_o,
  output logic        s_wb_stb_o,
  output logic [31:0] s_wb_adr_o,
  output logic [3:0]  s_wb_sel_o,
  output logic        s_wb_we_o,
  output logic [31:0] s_wb_dat_o,
  input  logic [31:0] s_wb_dat_i,
  input  logic        s_wb_ack_i,
  input  logic        s_wb_err_i,
  // grant status
  output logic [1:0]  gnt_o
);

  // The state encoding is the one-hot grant, so gnt_o is the state register itself.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_e;

  state_e state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   cyc_sel, stb_sel;
  logic   tmo_hit;

  // Next-state and round-robin pointer update
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (m0_wb_cyc_i && m1_wb_cyc_i) state_d = last_grant_q ? GNT0 : GNT1;
        else if (m0_wb_cyc_i)           state_d = GNT0;
        else if (m1_wb_cyc_i)           state_d = GNT1;
      end
      GNT0: if (!m0_wb_cyc_i) state_d = m1_wb_cyc_i ? GNT1 : IDLE;
      GNT1: if (!m1_wb_cyc_i) state_d = m0_wb_cyc_i ? GNT0 : IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == GNT0 && state_q != GNT0) last_grant_d = 1'b0;
    if (state_d == GNT1 && state_q != GNT1) last_grant_d = 1'b1;
  end

  // Grant state and round-robin pointer registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'(RESET_LAST_GRANT);
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef OR10_WB_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_q, tmo_cnt_d;

  // The counter only becomes nonzero while granted, so the state test only
  // guards the counter's reset value.
  assign tmo_hit = (state_q != IDLE) && (tmo_cnt_q == 16'(TIMEOUT_CYCLES));

  // Count stalled strobe cycles; any response, gap or grant change restarts it
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (tmo_hit || (state_d != state_q) || !stb_sel || s_wb_ack_i || s_wb_err_i)
      tmo_cnt_d = '0;
    else
      tmo_cnt_d = tmo_cnt_q + 16'd1;
  end

  // Watchdog counter register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) tmo_cnt_q <= '0;
    else          tmo_cnt_q <= tmo_cnt_d;
  end
`else
  // No watchdog is built: the arbiter waits indefinitely for ack or err.
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES == 0);
  assign tmo_hit        = 1'b0;
`endif

  // Slave-side request mux. Idle selects master 0 so the slave address bus
  // has a defined value.
  always_comb begin
    cyc_sel    = 1'b0;
    stb_sel    = 1'b0;
    s_wb_adr_o = m0_wb_adr_i;
    s_wb_sel_o = m0_wb_sel_i;
    s_wb_we_o  = m0_wb_we_i;
    s_wb_dat_o = m0_wb_dat_i;
    case (state_q)
      GNT0: begin
        cyc_sel = m0_wb_cyc_i;
        stb_sel = m0_wb_stb_i;
      end
      GNT1: begin
        cyc_sel    = m1_wb_cyc_i;
        stb_sel    = m1_wb_stb_i;
        s_wb_adr_o = m1_wb_adr_i;
        s_wb_sel_o = m1_wb_sel_i;
        s_wb_we_o  = m1_wb_we_i;
        s_wb_dat_o = m1_wb_dat_i;
      end
      default: ;
    endcase
  end

  // Reset forces the slave request low at once. It does not wait for the
  // state register to reach IDLE.
  assign s_wb_cyc_o = cyc_sel && !wb_rst_i;
  assign s_wb_stb_o = stb_sel && !wb_rst_i && !tmo_hit;

  // Responses are routed to the granted master only; idle drops them
  assign m0_wb_ack_o = (state_q == GNT0) && s_wb_ack_i && !wb_rst_i;
  assign m1_wb_ack_o = (state_q == GNT1) && s_wb_ack_i && !wb_rst_i;
  assign m0_wb_err_o = (state_q == GNT0) && (s_wb_err_i || tmo_hit) && !wb_rst_i;
  assign m1_wb_err_o = (state_q == GNT1) && (s_wb_err_i || tmo_hit) && !wb_rst_i;

  assign m0_wb_dat_o = s_wb_dat_i;
  assign m1_wb_dat_o = s_wb_dat_i;
  assign gnt_o       = state_q;

endmodule

// File: tb/tb_or10_wb_arbiter_2x1.sv
// Directed testbench for or10_wb_arbiter_2x1 (TIMEOUT_CYCLES=8, RESET_LAST_GRANT=1).
// Inputs change 2 ns after the rising edge. Outputs are checked 1 ns later.
module tb_or10_wb_arbiter_2x1;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_rdat, m1_rdat;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic [3:0]  s_sel;
  logic        s_ack, s_err;
  logic [1:0]  gnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  or10_wb_arbiter_2x1 #(.TIMEOUT_CYCLES(8), .RESET_LAST_GRANT(1)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_wb_cyc_i(m0_cyc), .m0_wb_stb_i(m0_stb), .m0_wb_adr_i(m0_adr),
    .m0_wb_sel_i(m0_sel), .m0_wb_we_i(m0_we), .m0_wb_dat_i(m0_dat),
    .m0_wb_dat_o(m0_rdat), .m0_wb_ack_o(m0_ack), .m0_wb_err_o(m0_err),
    .m1_wb_cyc_i(m1_cyc), .m1_wb_stb_i(m1_stb), .m1_wb_adr_i(m1_adr),
    .m1_wb_sel_i(m1_sel), .m1_wb_we_i(m1_we), .m1_wb_dat_i(m1_dat),
    .m1_wb_dat_o(m1_rdat), .m1_wb_ack_o(m1_ack), .m1_wb_err_o(m1_err),
    .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb), .s_wb_adr_o(s_adr),
    .s_wb_sel_o(s_sel), .s_wb_we_o(s_we), .s_wb_dat_o(s_wdat),
    .s_wb_dat_i(s_rdat), .s_wb_ack_i(s_ack), .s_wb_err_i(s_err),
    .gnt_o(gnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = 32'h0; m0_sel = 4'hF; m0_dat = 32'h0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = 32'h0; m1_sel = 4'hF; m1_dat = 32'h0;
    s_rdat = 32'h0; s_ack = 0; s_err = 0;
    tick(); tick();
    rst = 1'b0;
    #1;
    // reset state
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_scyc", s_cyc, 0);
    chk("rst_sstb", s_stb, 0);
    chk("rst_m0ack", m0_ack, 0);
    chk("rst_m1ack", m1_ack, 0);
    chk("rst_m0err", m0_err, 0);
    chk("rst_m1err", m1_err, 0);

    // slave ack while idle is dropped
    tick();
    s_ack = 1; s_err = 1; #1;
    chk("idle_m0ack", m0_ack, 0);
    chk("idle_m1ack", m1_ack, 0);
    chk("idle_m0err", m0_err, 0);
    chk("idle_m1err", m1_err, 0);
    tick();
    s_ack = 0; s_err = 0;

    // single m0 read at 0x10 with a 2-cycle slave
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0010; m0_sel = 4'h5; #1;
    chk("rd_gnt_req", gnt, 2'b00);
    chk("rd_scyc_req", s_cyc, 0);
    chk("rd_sadr_idle", s_adr, 32'h10);
    tick();
    chk("rd_gnt", gnt, 2'b01);
    chk("rd_scyc", s_cyc, 1);
    chk("rd_sstb", s_stb, 1);
    chk("rd_sadr", s_adr, 32'h10);
    chk("rd_ssel", s_sel, 4'h5);
    tick();
    s_ack = 1; s_rdat = 32'hCAFE_F00D; #1;
    chk("rd_m0ack", m0_ack, 1);
    chk("rd_m0dat", m0_rdat, 32'hCAFE_F00D);
    chk("rd_m1ack", m1_ack, 0);
    chk("rd_m1dat", m1_rdat, 32'hCAFE_F00D);
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0; #1;
    chk("rd_gnt_hold", gnt, 2'b01);
    chk("rd_scyc_drop", s_cyc, 0);
    tick();
    chk("rd_gnt_idle", gnt, 2'b00);

    // simultaneous requests after reset: m0, m1, m0 with no idle gap
    rst = 1; tick(); rst = 0;
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h100; m0_we = 1; m0_dat = 32'hAAAA_0000;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h200; m1_we = 0; m1_dat = 32'hBBBB_0000;
    tick();
    chk("rr1_gnt", gnt, 2'b01);
    chk("rr1_sadr", s_adr, 32'h100);
    chk("rr1_swe", s_we, 1);
    chk("rr1_sdat", s_wdat, 32'hAAAA_0000);
    s_ack = 1; #1;
    chk("rr1_m0ack", m0_ack, 1);
    chk("rr1_m1ack", m1_ack, 0);
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0; #1;
    chk("rr1_gnt_hold", gnt, 2'b01);
    tick();
    chk("rr2_gnt", gnt, 2'b10);
    chk("rr2_sadr", s_adr, 32'h200);
    chk("rr2_swe", s_we, 0);
    m0_cyc = 1; m0_stb = 1; s_ack = 1; #1;
    chk("rr2_m1ack", m1_ack, 1);
    chk("rr2_m0ack", m0_ack, 0);
    tick();
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
    tick();
    chk("rr3_gnt", gnt, 2'b01);
    chk("rr3_sadr", s_adr, 32'h100);
    s_ack = 1; #1;
    chk("rr3_m0ack", m0_ack, 1);
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    tick();
    chk("rr_idle", gnt, 2'b00);

    // m1 locks the bus over 4 strobe phases while m0 waits
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h300;
    tick();
    chk("lk_gnt", gnt, 2'b10);
    m0_cyc = 1; m0_stb = 1;
    for (int i = 0; i < 4; i++) begin
      s_ack = 1; #1;
      chk("lk_m1ack", m1_ack, 1);
      chk("lk_m0ack", m0_ack, 0);
      chk("lk_gnt_ph", gnt, 2'b10);
      tick();
      s_ack = 0; m1_stb = 0; #1;
      chk("lk_sstb_gap", s_stb, 0);
      chk("lk_gnt_gap", gnt, 2'b10);
      tick();
      m1_stb = 1;
    end
    m1_cyc = 0; m1_stb = 0; #1;
    chk("lk_gnt_drop", gnt, 2'b10);
    tick();
    chk("lk_gnt_m0", gnt, 2'b01);
    chk("lk_sadr_m0", s_adr, 32'h100);
    m0_cyc = 0; m0_stb = 0;
    tick();
    chk("lk_idle", gnt, 2'b00);

    // reset in the middle of an m0 transfer
    m0_cyc = 1; m0_stb = 1;
    tick();
    chk("mr_gnt", gnt, 2'b01);
    rst = 1; #1;
    chk("mr_scyc", s_cyc, 0);
    chk("mr_sstb", s_stb, 0);
    chk("mr_m0ack", m0_ack, 0);
    tick();
    chk("mr_gnt_after", gnt, 2'b00);
    m0_cyc = 0; m0_stb = 0; rst = 0;
    tick();

    // slave never answers
    m0_cyc = 1; m0_stb = 1;
    tick();
    chk("to_gnt", gnt, 2'b01);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("to_stall_err", m0_err, 0);
      chk("to_stall_stb", s_stb, 1);
      tick();
    end
    #1;
`ifdef OR10_WB_ARB_TIMEOUT_EN
    chk("to_err", m0_err, 1);
    chk("to_stb_forced", s_stb, 0);
    chk("to_m1err", m1_err, 0);
    chk("to_gnt_keep", gnt, 2'b01);
    tick();
    chk("to_err_once", m0_err, 0);
    chk("to_stb_back", s_stb, 1);
`else
    for (int i = 0; i < 12; i++) begin
      chk("to_no_err", m0_err, 0);
      chk("to_stb_held", s_stb, 1);
      tick();
      #1;
    end
`endif
    m0_cyc = 0; m0_stb = 0;
    tick(); tick();
    chk("end_idle", gnt, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
